// File: rtl/vr_fifo.sv
// Valid/ready FIFO with occupancy count and sticky overflow/underflow-attempt flags.
// FWFT=0 adds a head output register that is part of the occupancy count.
module vr_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 4,
    parameter bit          FWFT       = 1'b1,
    parameter bit [1023:0] RESET_DATA = '0
) (
    input  logic                       i_clk,
    input  logic                       i_arst_n,
    input  logic                       i_flush,
    input  logic                       i_vld,
    output logic                       o_rdy,
    input  logic [WIDTH-1:0]           i_data,
    output logic                       o_vld,
    input  logic                       i_rdy,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_ovf,
    output logic                       o_unf
);
    localparam int unsigned      CW       = $clog2(DEPTH + 1);
    localparam int unsigned      PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0]    LAST_PTR = PW'(DEPTH - 1);
    localparam logic [WIDTH-1:0] RST_DATA = RESET_DATA[WIDTH-1:0];

    if (DEPTH < 2 || WIDTH == 0 || WIDTH > 1024) begin : g_param_check
        $error("vr_fifo: illegal parameters WIDTH=%0d DEPTH=%0d", WIDTH, DEPTH);
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    logic             rd_adv;

    // Ready comes only from the registered count, never from i_rdy.
    assign o_rdy   = (count != FULL_CNT);
    assign push    = i_vld & o_rdy;
    assign pop     = o_vld & i_rdy;
    assign o_count = count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (push && !i_flush) begin
            mem[wp] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            o_ovf <= 1'b0;
            o_unf <= 1'b0;
        end else if (i_flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            o_ovf <= 1'b0;
            o_unf <= 1'b0;
        end else begin
            if (push) begin
                wp <= ptr_inc(wp);
            end
            if (rd_adv) begin
                rp <= ptr_inc(rp);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (i_vld && !o_rdy) begin
                o_ovf <= 1'b1;
            end
            if (i_rdy && !o_vld) begin
                o_unf <= 1'b1;
            end
        end
    end

    if (FWFT) begin : g_fwft
        assign rd_adv = pop;
        assign o_vld  = (count != '0);
        assign o_data = o_vld ? mem[rp] : RST_DATA;
    end else begin : g_outreg
        logic             out_vld;
        logic [WIDTH-1:0] out_data;
        logic             mem_avail;
        logic             load;

        // Storage holds everything except the word sitting in the output register.
        assign mem_avail = (count != CW'(out_vld));
        assign load      = mem_avail && (!out_vld || i_rdy);
        assign rd_adv    = load;
        assign o_vld     = out_vld;
        assign o_data    = out_data;

        always_ff @(posedge i_clk or negedge i_arst_n) begin
            if (!i_arst_n) begin
                out_vld  <= 1'b0;
                out_data <= RST_DATA;
            end else if (i_flush) begin
                out_vld  <= 1'b0;
                out_data <= RST_DATA;
            end else if (load) begin
                out_vld  <= 1'b1;
                out_data <= mem[rp];
            end else if (pop) begin
                out_vld  <= 1'b0;
                out_data <= RST_DATA;
            end
        end
    end

endmodule

// File: tb/tb_vr_fifo.sv
// Bench for vr_fifo: three configurations driven by shared stimulus, each checked
// every cycle against an occupancy/ordering model, plus vector table and corner sequences.
module tb_vr_fifo;
    logic       clk = 1'b0;
    logic       arst_n;
    logic       flush;
    logic       vld;
    logic       rdy;
    logic [7:0] din;

    always #5 clk = ~clk;

    logic       rdy_a, vld_a, ovf_a, unf_a;
    logic [7:0] data_a;
    logic [2:0] cnt_a;
    logic       rdy_b, vld_b, ovf_b, unf_b;
    logic [7:0] data_b;
    logic [1:0] cnt_b;
    logic       rdy_c, vld_c, ovf_c, unf_c;
    logic [7:0] data_c;
    logic [2:0] cnt_c;

    vr_fifo #(.WIDTH(8), .DEPTH(4), .FWFT(1'b1), .RESET_DATA(1024'h5A)) u_a (
        .i_clk(clk), .i_arst_n(arst_n), .i_flush(flush), .i_vld(vld), .o_rdy(rdy_a),
        .i_data(din), .o_vld(vld_a), .i_rdy(rdy), .o_data(data_a), .o_count(cnt_a),
        .o_ovf(ovf_a), .o_unf(unf_a));

    vr_fifo #(.WIDTH(8), .DEPTH(3), .FWFT(1'b1), .RESET_DATA(1024'h5A)) u_b (
        .i_clk(clk), .i_arst_n(arst_n), .i_flush(flush), .i_vld(vld), .o_rdy(rdy_b),
        .i_data(din), .o_vld(vld_b), .i_rdy(rdy), .o_data(data_b), .o_count(cnt_b),
        .o_ovf(ovf_b), .o_unf(unf_b));

    vr_fifo #(.WIDTH(8), .DEPTH(4), .FWFT(1'b0), .RESET_DATA(1024'h5A)) u_c (
        .i_clk(clk), .i_arst_n(arst_n), .i_flush(flush), .i_vld(vld), .o_rdy(rdy_c),
        .i_data(din), .o_vld(vld_c), .i_rdy(rdy), .o_data(data_c), .o_count(cnt_c),
        .o_ovf(ovf_c), .o_unf(unf_c));

    logic       d_rdy [3];
    logic       d_vld [3];
    logic       d_ovf [3];
    logic       d_unf [3];
    logic [7:0] d_data [3];
    logic [2:0] d_cnt [3];

    always_comb begin
        d_rdy[0] = rdy_a;  d_vld[0] = vld_a;  d_ovf[0] = ovf_a;  d_unf[0] = unf_a;
        d_rdy[1] = rdy_b;  d_vld[1] = vld_b;  d_ovf[1] = ovf_b;  d_unf[1] = unf_b;
        d_rdy[2] = rdy_c;  d_vld[2] = vld_c;  d_ovf[2] = ovf_c;  d_unf[2] = unf_c;
        d_data[0] = data_a; d_data[1] = data_b; d_data[2] = data_c;
        d_cnt[0] = cnt_a;  d_cnt[1] = {1'b0, cnt_b};  d_cnt[2] = cnt_c;
    end

    // Model: words in a ring indexed by push/pop totals; each word remembers the edge
    // that stored it, since without FWFT a word is only visible one edge after storage.
    logic [7:0] m_data [3][64];
    int         m_ts [3][64];
    int         m_wr [3];
    int         m_rd [3];
    bit         m_ovf [3];
    bit         m_unf [3];
    int         edge_cnt;
    int         n_tests;
    int         n_fail;

    typedef struct {
        bit         v;
        bit         r;
        bit         f;
        logic [7:0] d;
        bit         e_rdy;
        bit         e_vld;
        logic [7:0] e_data;
        logic [2:0] e_cnt;
        bit         e_ovf;
        bit         e_unf;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mkv(input bit v, input bit r, input bit f, input logic [7:0] d,
                                 input bit er, input bit ev, input logic [7:0] ed,
                                 input logic [2:0] ec, input bit eo, input bit eu);
        vec_t t;
        t.v = v; t.r = r; t.f = f; t.d = d;
        t.e_rdy = er; t.e_vld = ev; t.e_data = ed; t.e_cnt = ec; t.e_ovf = eo; t.e_unf = eu;
        return t;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 1) ? 3 : 4;
    endfunction

    function automatic bit m_vld(input int k);
        if (m_wr[k] == m_rd[k]) return 1'b0;
        if (k != 2) return 1'b1;
        return m_ts[k][m_rd[k] % 64] < edge_cnt;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_wr[k] = 0; m_rd[k] = 0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            int sz;
            bit v;
            sz = m_wr[k] - m_rd[k];
            v  = m_vld(k);
            chk($sformatf("u%0d o_rdy", k), 32'(d_rdy[k]), 32'(sz != depth_of(k)));
            chk($sformatf("u%0d o_vld", k), 32'(d_vld[k]), 32'(v));
            chk($sformatf("u%0d o_count", k), 32'(d_cnt[k]), 32'(sz));
            chk($sformatf("u%0d o_data", k), 32'(d_data[k]),
                32'(v ? m_data[k][m_rd[k] % 64] : 8'h5A));
            chk($sformatf("u%0d o_ovf", k), 32'(d_ovf[k]), 32'(m_ovf[k]));
            chk($sformatf("u%0d o_unf", k), 32'(d_unf[k]), 32'(m_unf[k]));
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int sz;
            bit v;
            sz = m_wr[k] - m_rd[k];
            v  = m_vld(k);
            if (flush) begin
                m_wr[k] = 0; m_rd[k] = 0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
            end else begin
                if (vld && sz == depth_of(k)) m_ovf[k] = 1'b1;
                if (rdy && !v) m_unf[k] = 1'b1;
                if (v && rdy) m_rd[k]++;
                if (vld && sz < depth_of(k)) begin
                    m_data[k][m_wr[k] % 64] = din;
                    m_ts[k][m_wr[k] % 64]   = edge_cnt + 1;
                    m_wr[k]++;
                end
            end
        end
        edge_cnt++;
    endtask

    task automatic drive(input bit v, input bit r, input bit f, input logic [7:0] d);
        vld = v; rdy = r; flush = f; din = d;
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cyc(input bit v, input bit r, input bit f, input logic [7:0] d);
        drive(v, r, f, d);
        @(negedge clk);
        check_all();
        advance();
    endtask

    logic [7:0] nxt;
    int         out_exp;
    bit         push_ok;

    initial begin
        n_tests = 0; n_fail = 0; edge_cnt = 0;
        model_reset();
        arst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;

        for (int i = 0; i < 5; i++) tbl[i] = mkv(0,0,0,8'h00, 1,0,8'h5A,3'd0,0,0);
        tbl[5]  = mkv(1,0,0,8'h11, 1,0,8'h5A,3'd0,0,0);
        tbl[6]  = mkv(1,0,0,8'h22, 1,1,8'h11,3'd1,0,0);
        tbl[7]  = mkv(1,0,0,8'h33, 1,1,8'h11,3'd2,0,0);
        tbl[8]  = mkv(1,0,0,8'h44, 1,1,8'h11,3'd3,0,0);
        tbl[9]  = mkv(1,0,0,8'h55, 0,1,8'h11,3'd4,0,0);
        tbl[10] = mkv(0,1,0,8'h00, 0,1,8'h11,3'd4,1,0);
        tbl[11] = mkv(0,1,0,8'h00, 1,1,8'h22,3'd3,1,0);
        tbl[12] = mkv(0,1,0,8'h00, 1,1,8'h33,3'd2,1,0);
        tbl[13] = mkv(0,1,0,8'h00, 1,1,8'h44,3'd1,1,0);
        tbl[14] = mkv(0,1,0,8'h00, 1,0,8'h5A,3'd0,1,0);
        tbl[15] = mkv(0,0,0,8'h00, 1,0,8'h5A,3'd0,1,1);
        tbl[16] = mkv(1,0,1,8'h99, 1,0,8'h5A,3'd0,1,1);
        tbl[17] = mkv(0,0,0,8'h00, 1,0,8'h5A,3'd0,0,0);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].d);
            @(negedge clk);
            check_all();
            chk($sformatf("vec%0d o_rdy", i), 32'(rdy_a), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d o_vld", i), 32'(vld_a), 32'(tbl[i].e_vld));
            chk($sformatf("vec%0d o_data", i), 32'(data_a), 32'(tbl[i].e_data));
            chk($sformatf("vec%0d o_count", i), 32'(cnt_a), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d o_ovf", i), 32'(ovf_a), 32'(tbl[i].e_ovf));
            chk($sformatf("vec%0d o_unf", i), 32'(unf_a), 32'(tbl[i].e_unf));
            advance();
        end

        // Streaming with both sides busy starting from full; producer holds data until accepted.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'(i));
        nxt = 8'd4;
        out_exp = 0;
        for (int i = 0; i < 26; i++) begin
            drive(i < 20, 1'b1, 1'b0, nxt);
            @(negedge clk);
            check_all();
            if (vld_a) begin
                chk("stream order", 32'(data_a), 32'(out_exp));
                out_exp++;
            end
            push_ok = (i < 20) && ((m_wr[0] - m_rd[0]) < 4);
            advance();
            if (push_ok) nxt++;
        end
        chk("stream total", 32'(out_exp), 32'(nxt));

        // DEPTH=3 wrap: push 0..9, pops trail by one cycle.
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        out_exp = 0;
        for (int t = 0; t < 11; t++) begin
            drive(t < 10, t >= 1, 1'b0, 8'(t));
            @(negedge clk);
            check_all();
            if (vld_b) begin
                chk("wrap order", 32'(data_b), 32'(out_exp));
                out_exp++;
            end
            advance();
        end
        chk("wrap total", 32'(out_exp), 32'd10);

        // First-word latency, FWFT=1 vs FWFT=0.
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'hA5);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check_all();
        chk("lat N+1 fwft vld", 32'(vld_a), 32'd1);
        chk("lat N+1 fwft data", 32'(data_a), 32'hA5);
        chk("lat N+1 reg vld", 32'(vld_c), 32'd0);
        chk("lat N+1 reg data", 32'(data_c), 32'h5A);
        advance();
        @(negedge clk);
        check_all();
        chk("lat N+2 reg vld", 32'(vld_c), 32'd1);
        chk("lat N+2 reg data", 32'(data_c), 32'hA5);
        advance();
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 8'h00);

        // Flush with count=2 and overflow set, alongside a push.
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h11 * (i + 1)));
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b1, 8'h77);
        @(negedge clk);
        check_all();
        chk("pre-flush count", 32'(cnt_a), 32'd2);
        chk("pre-flush ovf", 32'(ovf_a), 32'd1);
        advance();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check_all();
        chk("flush count", 32'(cnt_a), 32'd0);
        chk("flush ovf", 32'(ovf_a), 32'd0);
        chk("flush vld", 32'(vld_a), 32'd0);
        chk("flush data", 32'(data_a), 32'h5A);
        advance();
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset between edges with data stored and flags set.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'hD0 + i));
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        #2 arst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("arst u%0d o_vld", k), 32'(d_vld[k]), 32'd0);
            chk($sformatf("arst u%0d o_rdy", k), 32'(d_rdy[k]), 32'd1);
            chk($sformatf("arst u%0d o_count", k), 32'(d_cnt[k]), 32'd0);
            chk($sformatf("arst u%0d o_ovf", k), 32'(d_ovf[k]), 32'd0);
            chk($sformatf("arst u%0d o_unf", k), 32'(d_unf[k]), 32'd0);
            chk($sformatf("arst u%0d o_data", k), 32'(d_data[k]), 32'h5A);
        end
        model_reset();
        @(posedge clk);
        #1 arst_n = 1'b1;

        // Random traffic in fill-biased, drain-biased and balanced phases.
        for (int i = 0; i < 900; i++) begin
            int unsigned ph;
            int unsigned pv;
            int unsigned pr;
            ph = (i / 150) % 3;
            pv = (ph == 0) ? 3 : (ph == 1) ? 1 : 2;
            pr = (ph == 0) ? 1 : (ph == 1) ? 3 : 2;
            cyc($urandom_range(0, 3) < pv, $urandom_range(0, 3) < pr,
                $urandom_range(0, 63) == 0, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
